// File: rtl/keypad_scanner.sv
// Matrix keypad scanner: column-at-a-time drive, synchronised row sense,
// per-key debounce with a shared sample datapath, and a press/release event FIFO.
module keypad_scanner #(
    parameter  int COLS          = 4,
    parameter  int ROWS          = 4,
    parameter  int SETTLE_CYCLES = 16000,
    parameter  int DEBOUNCE      = 4,
    parameter  int FIFO_DEPTH    = 8,
    localparam int NK            = ROWS * COLS,
    localparam int KW            = (NK > 1) ? $clog2(NK) : 1
) (
    input  logic            clk,
    input  logic            rst_n,
    output logic [COLS-1:0] col_pins,
    input  logic [ROWS-1:0] row_pins,
    output logic [NK-1:0]   keys,
    output logic            ev_valid,
    output logic [KW-1:0]   ev_key,
    output logic            ev_pressed,
    input  logic            ev_ready,
    output logic            overflow,
    input  logic            overflow_clr,
    output logic            scan_done
);

    localparam int RW  = (ROWS > 1) ? $clog2(ROWS) : 1;
    localparam int CLW = (COLS > 1) ? $clog2(COLS) : 1;
    localparam int SW  = $clog2(SETTLE_CYCLES);
    localparam int DW  = $clog2(DEBOUNCE) + 1;
    localparam int AW  = $clog2(FIFO_DEPTH);
    localparam int EW  = KW + 1;

    typedef enum logic {S_SETTLE, S_SAMPLE} state_t;

    logic [ROWS-1:0] r_row_meta;
    logic [ROWS-1:0] r_row_s;
    state_t          r_state;
    logic [SW-1:0]   r_settle;
    logic [RW-1:0]   r_row;
    logic [CLW-1:0]  r_col;
    logic [NK-1:0]   r_keys;
    logic [DW-1:0]   r_cnt [NK];
    logic            r_scan_done;

    logic [EW-1:0]   r_mem [FIFO_DEPTH];
    logic [AW-1:0]   r_wr;
    logic [AW-1:0]   r_rd;
    logic [AW:0]     r_count;
    logic            r_ovf;

    logic [ROWS-1:0] w_raw;
    logic [KW-1:0]   w_key;
    logic            w_sample;
    logic            w_hit;
    logic            w_cur;
    logic [DW-1:0]   w_cnt;
    logic            w_flip;
    logic            w_last_row;
    logic            w_last_col;
    logic            w_full;
    logic            w_pop;
    logic            w_wr;
    logic            w_drop;
    logic [EW-1:0]   w_head;

    // Rows idle high, so the synchroniser resets to "nothing pressed".
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_row_meta <= '1;
            r_row_s    <= '1;
        end else begin
            r_row_meta <= row_pins;
            r_row_s    <= r_row_meta;
        end
    end

    assign w_raw      = ~r_row_s;
    assign w_key      = KW'(int'(r_row) * COLS + int'(r_col));
    assign w_sample   = (r_state == S_SAMPLE);
    assign w_hit      = w_raw[r_row];
    assign w_cur      = r_keys[w_key];
    assign w_cnt      = r_cnt[w_key];
    assign w_flip     = w_sample && (w_hit != w_cur) && (w_cnt == DW'(DEBOUNCE - 1));
    assign w_last_row = (r_row == RW'(ROWS - 1));
    assign w_last_col = (r_col == CLW'(COLS - 1));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state     <= S_SETTLE;
            r_settle    <= '0;
            r_row       <= '0;
            r_col       <= '0;
            r_keys      <= '0;
            r_scan_done <= 1'b0;
            for (int i = 0; i < NK; i++) r_cnt[i] <= '0;
        end else begin
            r_scan_done <= 1'b0;
            case (r_state)
                S_SETTLE: begin
                    if (r_settle == SW'(SETTLE_CYCLES - 1)) begin
                        r_state <= S_SAMPLE;
                        r_row   <= '0;
                    end else begin
                        r_settle <= r_settle + 1'b1;
                    end
                end
                S_SAMPLE: begin
                    if (w_hit == w_cur) begin
                        r_cnt[w_key] <= '0;
                    end else if (w_flip) begin
                        r_keys[w_key] <= ~w_cur;
                        r_cnt[w_key]  <= '0;
                    end else begin
                        r_cnt[w_key] <= w_cnt + 1'b1;
                    end
                    if (w_last_row) begin
                        r_row       <= '0;
                        r_settle    <= '0;
                        r_state     <= S_SETTLE;
                        r_col       <= w_last_col ? '0 : r_col + 1'b1;
                        r_scan_done <= w_last_col;
                    end else begin
                        r_row <= r_row + 1'b1;
                    end
                end
                default: r_state <= S_SETTLE;
            endcase
        end
    end

    assign col_pins  = ~(COLS'(1) << r_col);
    assign keys      = r_keys;
    assign scan_done = r_scan_done;

    // A pop in the same cycle frees a slot, so a full FIFO still accepts the push.
    assign w_full = (r_count == (AW + 1)'(FIFO_DEPTH));
    assign w_pop  = ev_valid && ev_ready;
    assign w_wr   = w_flip && (!w_full || w_pop);
    assign w_drop = w_flip && w_full && !w_pop;

    always_ff @(posedge clk) begin
        if (w_wr) r_mem[r_wr] <= {w_key, ~w_cur};
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_wr    <= '0;
            r_rd    <= '0;
            r_count <= '0;
            r_ovf   <= 1'b0;
        end else begin
            if (w_wr)  r_wr <= r_wr + 1'b1;
            if (w_pop) r_rd <= r_rd + 1'b1;
            if (w_wr && !w_pop)      r_count <= r_count + 1'b1;
            else if (!w_wr && w_pop) r_count <= r_count - 1'b1;
            if (w_drop)            r_ovf <= 1'b1;
            else if (overflow_clr) r_ovf <= 1'b0;
        end
    end

    assign ev_valid = (r_count != '0);
    assign w_head   = r_mem[r_rd];
    assign {ev_key, ev_pressed} = ev_valid ? w_head : '0;
    assign overflow = r_ovf;

endmodule

// File: tb/tb_keypad_scanner.sv
// Bench for keypad_scanner: a physical keypad model drives the rows, and a
// sweep-timed debounce/FIFO reference model predicts keys, events and flags.
module tb_keypad_scanner;

    localparam int COLS = 4, ROWS = 4, SETTLE = 4, DB = 3, DEPTH = 4;
    localparam int NK = ROWS * COLS, CP = SETTLE + ROWS, SP = COLS * CP;

    logic            clk = 1'b0;
    logic            rst_n = 1'b0;
    logic [COLS-1:0] col_pins;
    logic [ROWS-1:0] row_pins;
    logic [NK-1:0]   keys;
    logic            ev_valid;
    logic [3:0]      ev_key;
    logic            ev_pressed;
    logic            ev_ready = 1'b0;
    logic            overflow;
    logic            overflow_clr = 1'b0;
    logic            scan_done;
    logic [NK-1:0]   phys = '0;

    keypad_scanner #(
        .COLS(COLS), .ROWS(ROWS), .SETTLE_CYCLES(SETTLE), .DEBOUNCE(DB), .FIFO_DEPTH(DEPTH)
    ) dut (
        .clk(clk), .rst_n(rst_n), .col_pins(col_pins), .row_pins(row_pins), .keys(keys),
        .ev_valid(ev_valid), .ev_key(ev_key), .ev_pressed(ev_pressed), .ev_ready(ev_ready),
        .overflow(overflow), .overflow_clr(overflow_clr), .scan_done(scan_done)
    );

    always #5 clk = ~clk;

    // Physical matrix: a pressed key pulls its row low while its column is driven.
    always_comb begin
        row_pins = '1;
        for (int r = 0; r < ROWS; r++)
            for (int c = 0; c < COLS; c++)
                if (!col_pins[c] && phys[r*COLS+c]) row_pins[r] = 1'b0;
    end

    logic [NK-1:0] mkeys;
    int            mcnt [NK];
    logic [4:0]    mq [$];
    logic          movf;
    int            pass_cnt = 0;
    int            total = 0;
    int            rdy_mode = 0;
    int            pop_at = -1;
    int            clr_at = -1;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) pass_cnt++;
        else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    endtask

    task automatic model_reset();
        mkeys = '0;
        foreach (mcnt[i]) mcnt[i] = 0;
        mq.delete();
        movf = 1'b0;
    endtask

    // Edge e (1..SP) of a sweep samples key r*COLS+c at e = c*CP + SETTLE + 1 + r.
    task automatic model_edge(input int e, input logic rdy, input logic clr);
        logic push, drop;
        logic [4:0] ev;
        int t, c, r, k;
        push = 1'b0;
        drop = 1'b0;
        ev = '0;
        if (e >= SETTLE + 1) begin
            t = e - SETTLE - 1;
            c = t / CP;
            r = t % CP;
            if (r < ROWS) begin
                k = r * COLS + c;
                if (phys[k] != mkeys[k]) begin
                    if (mcnt[k] == DB - 1) begin
                        mkeys[k] = ~mkeys[k];
                        mcnt[k] = 0;
                        push = 1'b1;
                        ev = {4'(k), mkeys[k]};
                    end else mcnt[k]++;
                end else mcnt[k] = 0;
            end
        end
        if (rdy && mq.size() > 0) void'(mq.pop_front());
        if (push) begin
            if (mq.size() < DEPTH) mq.push_back(ev);
            else drop = 1'b1;
        end
        if (clr) movf = 1'b0;
        if (drop) movf = 1'b1;
    endtask

    task automatic cycle(input int e);
        logic rdy, clr;
        logic [3:0] exp_col;
        @(negedge clk);
        case (rdy_mode)
            0:       rdy = 1'b0;
            1:       rdy = 1'b1;
            2:       rdy = 1'($urandom_range(0, 1));
            default: rdy = (e == pop_at);
        endcase
        clr = (e == clr_at) || (rdy_mode == 2 && $urandom_range(0, 15) == 0);
        ev_ready = rdy;
        overflow_clr = clr;
        chk("ev_valid", 32'(ev_valid), 32'(mq.size() != 0));
        if (mq.size() != 0) chk("ev_head", 32'({ev_key, ev_pressed}), 32'(mq[0]));
        @(posedge clk);
        model_edge(e, rdy, clr);
        #1;
        exp_col = ~(4'b0001 << ((e / CP) % COLS));
        chk("scan_done", 32'(scan_done), 32'(e == SP));
        chk("col_pins", 32'(col_pins), 32'(exp_col));
        chk("keys", 32'(keys), 32'(mkeys));
        chk("overflow", 32'(overflow), 32'(movf));
    endtask

    task automatic run_sweeps(input int n, input logic [NK-1:0] p);
        phys = p;
        repeat (n) for (int e = 1; e <= SP; e++) cycle(e);
        ev_ready = 1'b0;
        overflow_clr = 1'b0;
    endtask

    initial begin
        logic [NK-1:0] p;
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        chk("rst_col", 32'(col_pins), 32'(4'b1110));
        chk("rst_keys", 32'(keys), 32'h0);
        chk("rst_valid", 32'(ev_valid), 32'h0);
        chk("rst_evkey", 32'({ev_key, ev_pressed}), 32'h0);
        chk("rst_ovf", 32'(overflow), 32'h0);
        chk("rst_done", 32'(scan_done), 32'h0);
        rst_n = 1'b1;

        // Idle sweep: column walk and scan_done cadence.
        run_sweeps(1, '0);

        // Single press/release of key 6.
        run_sweeps(3, 16'h0040);
        chk("t2_key6", 32'(keys[6]), 32'h1);
        chk("t2_ev", 32'({ev_valid, ev_key, ev_pressed}), 32'({1'b1, 4'd6, 1'b1}));
        rdy_mode = 3; pop_at = 2;
        run_sweeps(1, 16'h0040);
        chk("t2_popped", 32'(ev_valid), 32'h0);
        rdy_mode = 0;
        run_sweeps(3, '0);
        chk("t2_rel", 32'({ev_valid, ev_key, ev_pressed}), 32'({1'b1, 4'd6, 1'b0}));
        rdy_mode = 3; pop_at = 2;
        run_sweeps(1, '0);
        rdy_mode = 0;

        // Bounce shorter than the debounce window.
        run_sweeps(2, 16'h0040);
        run_sweeps(1, '0);
        chk("t3_key6", 32'(keys[6]), 32'h0);
        chk("t3_noev", 32'(ev_valid), 32'h0);

        // Overflow: five presses into a four-deep FIFO.
        run_sweeps(3, 16'h1113);
        chk("t4_ovf", 32'(overflow), 32'h1);
        chk("t4_keys", 32'(keys), 32'h1113);
        chk("t4_head", 32'({ev_key, ev_pressed}), 32'({4'd0, 1'b1}));
        clr_at = 3;
        run_sweeps(1, 16'h1113);
        clr_at = -1;
        chk("t4_clr", 32'(overflow), 32'h0);

        // Full FIFO with a pop on the push cycle of key 2 (edge 21).
        run_sweeps(2, 16'h1117);
        rdy_mode = 3; pop_at = 2 * CP + SETTLE + 1;
        run_sweeps(1, 16'h1117);
        chk("t5_valid", 32'(ev_valid), 32'h1);
        chk("t5_head", 32'({ev_key, ev_pressed}), 32'({4'd4, 1'b1}));
        chk("t5_ovf", 32'(overflow), 32'h0);
        rdy_mode = 1;
        run_sweeps(1, 16'h1117);
        chk("t5_drained", 32'(ev_valid), 32'h0);

        // Reset mid-sample with three release events queued.
        rdy_mode = 0;
        run_sweeps(3, 16'h1006);
        for (int e = 1; e <= 6; e++) cycle(e);
        rst_n = 1'b0;
        #1;
        chk("t6_valid", 32'(ev_valid), 32'h0);
        chk("t6_keys", 32'(keys), 32'h0);
        chk("t6_col", 32'(col_pins), 32'(4'b1110));
        chk("t6_ovf", 32'(overflow), 32'h0);
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
        run_sweeps(1, 16'h1006);

        // Randomised key activity with random consumer and clears.
        p = 16'h1006;
        for (int i = 0; i < 24; i++) begin
            rdy_mode = ($urandom_range(0, 2) == 0) ? 0 : 2;
            if ($urandom_range(0, 1) == 0) p = p ^ (16'(1) << $urandom_range(0, NK - 1));
            run_sweeps(int'($urandom_range(1, 4)), p);
        end

        $display("%0d/%0d checks passed", pass_cnt, total);
        $finish;
    end

endmodule
